and16_share_arbiter: RTL and testbench
======================================

Name: and16_share_arbiter

Overview:
- Shares one instance of the 16-bit AND chip (and_16bit_chip) between two requesters.
- Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one requester per cycle round-robin, computes a & b, and holds the result in a single-entry output register tagged with the requester id.
- Sits between requester-side sequencers and any downstream consumer of AND results.
- Also keeps per-requester served counters for debug and fairness checks.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported because the shared chip is fixed at 16 bits.
- CNT_W, 8, width of each served counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_ready  output  1  requester 0 pair accepted this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a  input  WIDTH  requester 1 operand a
- req1_b  input  WIDTH  requester 1 operand b
- req1_ready  output  1  requester 1 pair accepted this cycle
- rsp_valid  output  1  result register holds a result
- rsp_data  output  WIDTH  registered a & b
- rsp_id  output  1  requester that owns rsp_data
- rsp_ready  input  1  consumer takes result this cycle
- served0_cnt  output  CNT_W  results accepted from requester 0
- served1_cnt  output  CNT_W  results accepted from requester 1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high; on reset assertion all state clears immediately without waiting for a clock edge.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, served0_cnt=0, served1_cnt=0, last_grant=1 (so requester 0 wins the first contention). req0_ready and req1_ready are 0 while reset is high.
- State machine, two states:
  - EMPTY: result slot free.
  - FULL: result slot holds an unconsumed result.
  - rsp_valid equals (state==FULL).
- Slot-free condition: slot_free = EMPTY or (FULL and rsp_ready). This allows back-to-back throughput of one result per cycle.
- Grant (combinational):
  - Arbitration runs only when slot_free.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not equal to last_grant is granted.
  - reqN_ready = grant_N. A ready is never asserted for an invalid requester.
  - Ready depends on valid and rsp_ready combinationally; there are no other combinational paths.
- Acceptance: a transfer occurs on the edge where reqN_valid and reqN_ready are both high. On that edge:
  - rsp_data <= reqN_a & reqN_b, computed through the single and_16bit_chip instance, whose inputs are muxed by grant.
  - rsp_id <= N.
  - state <= FULL.
  - last_grant <= N.
  - servedN_cnt increments.
- Latency: one cycle. A pair accepted at edge k is visible on rsp_* after edge k, and rsp_valid is high in cycle k+1.
- Drain: if FULL and rsp_ready and no grant, state <= EMPTY on that edge. If FULL and rsp_ready and a grant occurs, the slot is overwritten with the new result and state stays FULL.
- Hold: while FULL and not rsp_ready, rsp_data and rsp_id are stable, both readies are 0, and last_grant is unchanged.
- Requester rule: a requester must hold valid, a and b stable until accepted. The arbiter does not register requests; a dropped valid is simply not granted.
- Counters: wrap modulo 2^CNT_W (255 -> 0) and never saturate.
- Fairness: under continuous contention with rsp_ready=1, grants alternate 0,1,0,1. No requester waits more than one transfer.
- Reset mid-operation: asserting reset while FULL discards the pending result, so rsp_valid falls immediately. After reset deasserts, the first contention grants requester 0 again.

Test Plan:
- Single requester: reset, then req0 a=16'h25EE, b=16'hD1D6 with rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_data=16'h01C6, rsp_id=0, served0_cnt=1.
- Contention: req0 and req1 both valid continuously (req0 a=16'hFFFF, b=16'h0F0F; req1 a=16'hFFFF, b=16'hF0F0), rsp_ready=1 -> rsp_id sequence 0,1,0,1; rsp_data alternates 16'h0F0F and 16'hF0F0; rsp_valid is continuously 1 after the first accept.
- Backpressure: one result held with rsp_ready=0 for 5 cycles while req1 is valid -> both readies stay 0 and rsp_data is unchanged. Raising rsp_ready for one cycle consumes the held result and accepts req1 on the same edge.
- Edge operands: a=16'h0000, b=16'hFFFF -> 16'h0000; a=b=16'hFFFF -> 16'hFFFF; a=b=16'h0000 -> 16'h0000.
- Counter wrap: 256 accepts from requester 1 -> served1_cnt returns to 0 and served0_cnt is unchanged.
- Async reset: assert reset mid-cycle while FULL -> rsp_valid, rsp_data and the counters go to 0 before the next clock edge. After release, with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/and16_share_arbiter.sv
// Two-requester round-robin front end for one shared 16-bit AND chip.
// A single-entry result register is tagged with the id of the requester that owns the result.

module and_16bit_chip (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);
    assign y_o = a_i & b_i;
endmodule

// Handshake: a pair moves on the rising edge where reqN_valid && reqN_ready.
// A result moves on the rising edge where rsp_valid && rsp_ready.
// A requester holds valid, a and b stable until its pair is accepted.
module and16_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] served0_cnt,
    output logic [CNT_W-1:0] served1_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   served0_q, served0_d;
    logic [CNT_W-1:0]   served1_q, served1_d;

    logic               slot_free;
    logic               grant0, grant1;
    logic [WIDTH-1:0]   chip_a, chip_b, chip_y;

    // Readies are forced low while reset is held so nothing is accepted during reset.
    always_comb begin
        slot_free = (state_q == EMPTY) || rsp_ready;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!reset && slot_free) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign chip_a = grant1 ? req1_a : req0_a;
    assign chip_b = grant1 ? req1_b : req0_b;

    and_16bit_chip u_chip (
        .a_i (chip_a),
        .b_i (chip_b),
        .y_o (chip_y)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        served0_d    = served0_q;
        served1_d    = served1_q;
        if (grant0 || grant1) begin
            // A grant while FULL only happens with rsp_ready, so overwriting is a drain plus refill.
            state_d      = FULL;
            rsp_data_d   = chip_y;
            rsp_id_d     = grant1;
            last_grant_d = grant1;
            if (grant0) served0_d = served0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (grant1) served1_d = served1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            served0_q    <= '0;
            served1_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            served0_q    <= served0_d;
            served1_q    <= served1_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp_valid   = (state_q == FULL);
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign served0_cnt = served0_q;
    assign served1_cnt = served1_q;
endmodule

// File: tb/tb_and16_share_arbiter.sv
// Bench for and16_share_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every falling edge against a behavioural model.

module tb_and16_share_arbiter;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready = 1'b0;
    logic [CNT_W-1:0] served0_cnt, served1_cnt;

    int vectors = 0;
    int miscompares = 0;

    and16_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready),
        .served0_cnt (served0_cnt),
        .served1_cnt (served1_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model: the slot, who won last, and how many results each side has had
    logic             m_full = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_id = 1'b0;
    logic             m_last = 1'b1;
    int               m_cnt[2] = '{0, 0};
    logic [1:0]       m_acc = 2'b00;

    // Who the spec says wins right now: nobody if blocked, else the lone asker, else the other side.
    function automatic logic [1:0] m_grant();
        if (reset) return 2'b00;
        if (m_full && !rsp_ready) return 2'b00;
        if (req0_valid && req1_valid) return (m_last == 1'b0) ? 2'b10 : 2'b01;
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_full = 1'b0; m_data = '0; m_id = 1'b0; m_last = 1'b1;
            m_cnt[0] = 0; m_cnt[1] = 0; m_acc = 2'b00;
        end else begin
            m_acc = m_grant();
            if (m_acc != 2'b00) begin
                int n;
                n = m_acc[1] ? 1 : 0;
                m_full = 1'b1;
                m_id   = m_acc[1];
                m_last = m_acc[1];
                m_data = n ? (req1_a & req1_b) : (req0_a & req0_b);
                m_cnt[n] = (m_cnt[n] + 1) % 256;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        logic [1:0] g;
        g = m_grant();
        check("req0_ready", 32'(req0_ready), 32'(g[0]));
        check("req1_ready", 32'(req1_ready), 32'(g[1]));
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("served0_cnt", 32'(served0_cnt), 32'(m_cnt[0]));
        check("served1_cnt", 32'(served1_cnt), 32'(m_cnt[1]));
        if (m_full) begin
            check("rsp_data", 32'(rsp_data), 32'(m_data));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_valid = v; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_valid = v; req1_a = a; req1_b = b;
    endtask

    // called at posedge+1: pulse reset well clear of the next edge
    task automatic do_reset();
        set0(1'b0, '0, '0);
        set1(1'b0, '0, '0);
        rsp_ready = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [WIDTH-1:0] edge_a[3] = '{16'h0000, 16'hFFFF, 16'h0000};
    logic [WIDTH-1:0] edge_b[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    logic [WIDTH-1:0] edge_y[3] = '{16'h0000, 16'hFFFF, 16'h0000};

    initial begin
        #1 reset = 1'b1;
        #11 reset = 1'b0;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);

        // single requester
        set0(1'b1, 16'h25EE, 16'hD1D6);
        rsp_ready = 1'b1;
        #1 check("single_ready", 32'(req0_ready), 32'd1);
        tick();
        set0(1'b0, '0, '0);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_data", 32'(rsp_data), 32'h01C6);
        check("single_id", 32'(rsp_id), 32'd0);
        check("single_cnt0", 32'(served0_cnt), 32'd1);
        tick();

        // contention: strict alternation starting with requester 0
        do_reset();
        tick();
        set0(1'b1, 16'hFFFF, 16'h0F0F);
        set1(1'b1, 16'hFFFF, 16'hF0F0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_valid", 32'(rsp_valid), 32'd1);
            check("cont_id", 32'(rsp_id), 32'(i % 2));
            check("cont_data", 32'(rsp_data), (i % 2) ? 32'hF0F0 : 32'h0F0F);
        end

        // backpressure
        do_reset();
        tick();
        set0(1'b1, 16'hF0F0, 16'h0FF0);
        tick();
        set0(1'b0, '0, '0);
        set1(1'b1, 16'hFFFF, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            check("bp_data", 32'(rsp_data), 32'h00F0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 check("bp_release_ready1", 32'(req1_ready), 32'd1);
        tick();
        set1(1'b0, '0, '0);
        check("bp_new_id", 32'(rsp_id), 32'd1);
        check("bp_new_data", 32'(rsp_data), 32'h1234);
        tick();

        // edge operands
        for (int i = 0; i < 3; i++) begin
            set0(1'b1, edge_a[i], edge_b[i]);
            tick();
            check("edge_data", 32'(rsp_data), 32'(edge_y[i]));
        end
        set0(1'b0, '0, '0);
        tick();

        // counter wrap
        do_reset();
        tick();
        rsp_ready = 1'b1;
        set1(1'b1, 16'(($urandom)), 16'(($urandom)));
        repeat (255) tick();
        check("wrap_255", 32'(served1_cnt), 32'd255);
        tick();
        check("wrap_0", 32'(served1_cnt), 32'd0);
        check("wrap_cnt0", 32'(served0_cnt), 32'd0);
        set1(1'b0, '0, '0);
        tick();

        // async reset while FULL
        set0(1'b1, 16'hFFFF, 16'hFFFF);
        rsp_ready = 1'b0;
        tick();
        set0(1'b0, '0, '0);
        check("ar_full", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(rsp_valid), 32'd0);
        check("ar_data", 32'(rsp_data), 32'd0);
        check("ar_cnt0", 32'(served0_cnt), 32'd0);
        check("ar_cnt1", 32'(served1_cnt), 32'd0);
        #1 reset = 1'b0;
        set0(1'b1, 16'h00FF, 16'h0FF0);
        set1(1'b1, 16'hFF00, 16'h0FF0);
        rsp_ready = 1'b1;
        #1;
        check("ar_first_g0", 32'(req0_ready), 32'd1);
        check("ar_first_g1", 32'(req1_ready), 32'd0);
        tick();
        check("ar_first_id", 32'(rsp_id), 32'd0);
        check("ar_first_data", 32'(rsp_data), 32'h00F0);

        // randomized traffic; requesters hold their pair until the model says it was taken
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid || m_acc[0])
                set0(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
            if (!req1_valid || m_acc[1])
                set1(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
